// File: rtl/pc_fetch.sv
// Instruction-fetch stage: owns the program counter, reads instruction
// memory over a req/ack handshake and presents if_pc/if_inst to IF/ID.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | one cycle after reset, nothing requested, nothing presented
// FETCH | imem_req held at pc until ack; a hit presents rdata this cycle
// READY | hit arrived while IF was stalled; instruction held in inst_buf
module pc_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        stallreq_if,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    READY = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_buf_q, inst_buf_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;

  logic        hit;
  logic [31:0] seq_pc;
  logic        stall_unused;

  // Only the PC/IF bit of the stall vector concerns this stage.
  assign stall_unused = ^stall[5:1];

  // A hit is an ack carrying data for the current pc that nobody wants to discard.
  assign hit = imem_ack & ~pend_q & ~flush;

  // Address that follows the presented instruction; the delay slot is the
  // instruction presented together with branch_flag_i.
  assign seq_pc = branch_flag_i ? branch_target_i : pc_q + 32'd4;

  // The address only ever moves on an ack or outside FETCH, so it is stable
  // for the whole life of a request.
  assign imem_addr = pc_q;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      inst_buf_q <= 32'h0;
      pend_q     <= 1'b0;
      pend_pc_q  <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_buf_q <= inst_buf_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
    end
  end

  // Next-state logic: flush > pending discard > advance > hold.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_buf_d = inst_buf_q;
    pend_d     = pend_q;
    pend_pc_d  = pend_pc_q;
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (flush) begin
          if (imem_ack) begin
            // Data for the old pc is dropped; refetch from the target.
            pc_d   = new_pc;
            pend_d = 1'b0;
          end else begin
            // Cannot retract the request; remember the target and
            // throw the data away when it finally arrives.
            pend_d    = 1'b1;
            pend_pc_d = new_pc;
          end
        end else if (imem_ack && pend_q) begin
          pc_d   = pend_pc_q;
          pend_d = 1'b0;
        end else if (hit) begin
          if (stall[0]) begin
            inst_buf_d = imem_rdata;
            state_d    = READY;
          end else begin
            pc_d = seq_pc;
          end
        end
      end
      READY: begin
        if (flush) begin
          pc_d    = new_pc;
          state_d = FETCH;
        end else if (!stall[0]) begin
          pc_d    = seq_pc;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs; stallreq_if depends on ack/state/pend/flush only, never on stall.
  always_comb begin
    imem_req    = 1'b0;
    stallreq_if = 1'b1;
    if_pc       = 32'h0;
    if_inst     = 32'h0;
    case (state_q)
      FETCH: begin
        imem_req    = 1'b1;
        if_pc       = pc_q;
        stallreq_if = ~hit;
        if (hit) begin
          if_inst = imem_rdata;
        end
      end
      READY: begin
        stallreq_if = 1'b0;
        if_pc       = pc_q;
        if_inst     = inst_buf_q;
      end
      default: begin
        imem_req    = 1'b0;
        stallreq_if = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Bench for pc_fetch: a behavioural instruction memory with configurable
// latency plus a transaction-level model of which address is being fetched,
// which instruction is held and which redirect is waiting.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_i;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stallreq_if;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  always #5 clk = ~clk;

  pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .flush          (flush),
    .new_pc         (new_pc),
    .branch_flag_i  (branch_flag_i),
    .branch_target_i(branch_target_i),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .stallreq_if    (stallreq_if),
    .if_pc          (if_pc),
    .if_inst        (if_inst)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory contents: a scrambled function of the address, so data never equals its address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Reference model state.
  bit          m_run;       // past the post-reset idle cycle
  bit          m_hold;      // an instruction is parked waiting for IF to unstall
  logic [31:0] m_hold_inst;
  logic [31:0] m_pc;        // address currently wanted from memory / presented
  bit          m_redir;     // a flush target waits for the outstanding read to finish
  logic [31:0] m_redir_pc;

  // Memory model state.
  int  lat_mode;            // <0: random 0..3 wait cycles per read
  bit  mem_busy;
  int  mem_cnt;
  int  mem_age;

  logic        last_stallreq;
  logic [31:0] last_if_pc;

  task automatic model_reset();
    m_run    = 0;
    m_hold   = 0;
    m_pc     = 32'h0;
    m_redir  = 0;
    mem_busy = 0;
    mem_cnt  = 0;
    mem_age  = 0;
  endtask

  // Asserts reset right now (asynchronously), checks idle outputs, and
  // releases it just after a rising edge so the next cycle is the idle one.
  task automatic do_reset();
    rst = 1'b0;
    #1;
    check_eq("rst_imem_req", imem_req, 1'b0);
    check_eq("rst_stallreq", stallreq_if, 1'b1);
    check_eq("rst_if_pc", if_pc, 32'h0);
    check_eq("rst_if_inst", if_inst, 32'h0);
    model_reset();
    imem_ack = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // One pipeline cycle: drive at the falling edge, check, then advance the model.
  task automatic cycle(input logic s0, input logic fl, input logic [31:0] npc,
                       input logic br, input logic [31:0] tgt);
    logic [4:0]  up;
    logic        exp_req;
    logic        delivered;
    logic [31:0] nxt;
    @(negedge clk);
    up              = 5'($urandom);
    stall           = {up, s0};
    flush           = fl;
    new_pc          = npc;
    branch_flag_i   = br;
    branch_target_i = tgt;
    exp_req = m_run && !m_hold;
    check_eq("imem_req", imem_req, exp_req);
    if (exp_req) check_eq("imem_addr", imem_addr, m_pc);
    if (exp_req) begin
      if (!mem_busy) begin
        mem_busy = 1;
        mem_age  = 0;
        mem_cnt  = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
      end
      imem_ack   = (mem_cnt == 0);
      imem_rdata = imem_ack ? mem_word(m_pc) : $urandom;
    end else begin
      mem_busy   = 0;
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
    end
    #1;
    delivered = exp_req && imem_ack && !m_redir && !fl;
    check_eq("stallreq_if", stallreq_if, !m_run ? 1'b1 : (m_hold ? 1'b0 : !delivered));
    check_eq("if_pc", if_pc, m_run ? m_pc : 32'h0);
    check_eq("if_inst", if_inst, !m_run ? 32'h0 : (m_hold ? m_hold_inst :
                                 (delivered ? mem_word(m_pc) : 32'h0)));
    if (stallreq_if === 1'b0) check_eq("inst_matches_pc", if_inst, mem_word(if_pc));
    last_stallreq = stallreq_if;
    last_if_pc    = if_pc;

    nxt = br ? tgt : m_pc + 32'd4;
    if (!m_run) begin
      m_run = 1;
    end else if (m_hold) begin
      if (fl) begin
        m_pc = npc; m_hold = 0;
      end else if (!s0) begin
        m_pc = nxt; m_hold = 0;
      end
    end else if (fl) begin
      if (imem_ack) begin
        m_pc = npc; m_redir = 0;
      end else begin
        m_redir = 1; m_redir_pc = npc;
      end
    end else if (imem_ack && m_redir) begin
      m_pc = m_redir_pc; m_redir = 0;
    end else if (imem_ack) begin
      if (s0) begin
        m_hold = 1; m_hold_inst = mem_word(m_pc);
      end else begin
        m_pc = nxt;
      end
    end
    if (exp_req) begin
      if (imem_ack) mem_busy = 0;
      else begin
        mem_cnt--;
        mem_age++;
      end
    end
  endtask

  initial begin
    bit          flushed, saw_target, saw_stale, f;
    logic [31:0] r1, r2;
    rst = 1'b1; stall = '0; flush = 0; new_pc = '0;
    branch_flag_i = 0; branch_target_i = '0; imem_ack = 0; imem_rdata = '0;
    lat_mode = 0;
    model_reset();
    #2;
    do_reset();

    // Zero-wait memory: one instruction per cycle.
    repeat (6) cycle(0, 0, 32'h0, 0, 32'h0);

    // Three wait cycles per read.
    lat_mode = 3;
    repeat (12) cycle(0, 0, 32'h0, 0, 32'h0);

    // Branch while 0x8 is presented: 0x8 is the delay slot, next fetch 0x100.
    do_reset();
    lat_mode = 0;
    for (int i = 0; i < 8; i++)
      cycle(0, 0, 32'h0, (m_run && !m_hold && m_pc == 32'h8), 32'h100);

    // Flush to 0x180 in the second cycle of a 4-cycle read of 0x20.
    do_reset();
    lat_mode = 0;
    cycle(0, 0, 32'h0, 0, 32'h0);
    cycle(0, 1, 32'h20, 0, 32'h0);
    lat_mode = 3;
    flushed = 0; saw_target = 0; saw_stale = 0;
    for (int i = 0; i < 20; i++) begin
      f = !flushed && mem_busy && mem_age == 1 && m_pc == 32'h20;
      cycle(0, f, 32'h180, 0, 32'h0);
      if (f) flushed = 1;
      if (flushed && !last_stallreq && last_if_pc == 32'h180) saw_target = 1;
      if (flushed && !last_stallreq && last_if_pc == 32'h20) saw_stale = 1;
    end
    check_eq("flush_target_presented", saw_target, 1'b1);
    check_eq("flush_stale_dropped", saw_stale, 1'b0);

    // Hit while IF is stalled: parked in the buffer, released later.
    do_reset();
    lat_mode = 1;
    for (int i = 0; i < 10; i++) cycle((i >= 1 && i < 5), 0, 32'h0, 0, 32'h0);

    // Sequential wrap past the top of the address space.
    do_reset();
    lat_mode = 0;
    cycle(0, 0, 32'h0, 0, 32'h0);
    cycle(0, 1, 32'hFFFF_FFF8, 0, 32'h0);
    repeat (4) cycle(0, 0, 32'h0, 0, 32'h0);

    // Reset in the middle of a wait.
    lat_mode = 3;
    repeat (2) cycle(0, 0, 32'h0, 0, 32'h0);
    #2;
    do_reset();

    // Random traffic.
    lat_mode = -1;
    for (int i = 0; i < 800; i++) begin
      r1 = $urandom;
      r2 = $urandom;
      if (r1[7:0] == 8'h00) r1 = 32'hFFFF_FFF0;
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), r1 & 32'hFFFF_FFFC,
            ($urandom_range(0, 4) == 0), r2 & 32'h0000_FFFC);
      if ($urandom_range(0, 249) == 0) begin
        #2;
        do_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
